// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage core's pipeline control.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register load/flush control: branch flush, load-use and structural
// stalls, ecall/ebreak halt draining, plus stall/flush performance counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_taken,
  input  logic                 load_use,
  input  logic                 mem_busy,
  input  logic                 halt_req,
  output logic                 pc_load,
  output logic                 ifid_load,
  output logic                 idex_load,
  output logic                 exmem_load,
  output logic                 memwb_load,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output state_t               state_dbg
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          flush_inc;
  logic          stall_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    flush_inc   = 1'b0;
    pc_load     = 1'b1;
    ifid_load   = 1'b1;
    idex_load   = 1'b1;
    exmem_load  = 1'b1;
    memwb_load  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halted      = 1'b0;

    if (rst) begin
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      idex_load   = 1'b0;
      exmem_load  = 1'b0;
      memwb_load  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      drain_d     = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          // A taken branch squashes everything younger, so the other requests are wrong-path.
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (halt_req) begin
            pc_load    = 1'b0;
            ifid_flush = 1'b1;
            state_d    = DRAIN;
            drain_d    = DW'(DRAIN_CYCLES - 1);
          end else if (load_use) begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_flush = 1'b1;
          end else if (mem_busy) begin
            pc_load    = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = RUN;
            drain_d     = '0;
          end else begin
            pc_load    = 1'b0;
            ifid_flush = 1'b1;
            if (drain_q == '0) begin
              state_d = HALT;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        HALT: begin
          pc_load    = 1'b0;
          ifid_load  = 1'b0;
          idex_load  = 1'b0;
          exmem_load = 1'b0;
          memwb_load = 1'b0;
          halted     = 1'b1;
        end
        default: begin
          state_d = RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  // DRAIN cycles count as stalls; HALT cycles do not.
  assign stall_inc = !rst && (state_q != HALT) && !pc_load;
  assign state_dbg = state_q;

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule
